// File: rtl/pc_seq_pkg.sv
// Shared types and default sizing for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } pc_state_e;

  localparam int unsigned D_DEF           = 12;
  localparam int unsigned LUT_AW_DEF      = 5;
  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned STACK_DEPTH_DEF = 4;

  localparam logic [LUT_AW_DEF-1:0] LUT_NULL_IDX = '0;

endpackage

// File: rtl/pc_link_stack.sv
// Return-address stack for call/ret; push and pop are ignored when full/empty.
module pc_link_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 12
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  // Entry selection by compare keeps indices free of width truncation.
  always_comb begin
    pop_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (cnt_q == CW'(i + 1)) pop_data = mem_q[i];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    mem_d = mem_q;
    if (clear) begin
      cnt_d = '0;
    end else if (push && !full) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (cnt_q == CW'(i)) mem_d[i] = push_data;
      end
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !empty) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC/fetch sequencer: IDLE/RUN/HALT FSM, next-PC mux, fault and jump counter.
// Optional call/ret link stack enabled with PC_LINK_STACK_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned D           = D_DEF,
  parameter int unsigned LUT_AW      = LUT_AW_DEF,
`ifdef PC_LINK_STACK_EN
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF,
`endif
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [D-1:0]      start_addr,
  input  logic              stall,
  input  logic              halt,
  input  logic              absjump_en,
  input  logic              branch_en,
  input  logic              branch_cond,
`ifdef PC_LINK_STACK_EN
  input  logic              call_en,
  input  logic              ret_en,
`endif
  input  logic [LUT_AW-1:0] lut_idx,
  output logic [LUT_AW-1:0] lut_addr,
  input  logic [D-1:0]      target,
  output logic [D-1:0]      prog_ctr,
  output logic              running,
  output logic              done,
  output logic              fault,
  output logic [CNT_W-1:0]  jump_cnt
);

  pc_state_e        state_q, state_d;
  logic [D-1:0]     pc_q, pc_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             take;
  logic             lut_null;

  assign lut_addr = lut_idx;
  assign take     = absjump_en | (branch_en & branch_cond);
  assign lut_null = (lut_idx == LUT_AW'(LUT_NULL_IDX));

`ifdef PC_LINK_STACK_EN
  logic         stk_push, stk_pop, stk_clear, stk_full, stk_empty;
  logic [D-1:0] stk_pop_data;

  pc_link_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (D)
  ) u_link_stack (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (stk_clear),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_q + D'(1)),
    .pop_data  (stk_pop_data),
    .full      (stk_full),
    .empty     (stk_empty)
  );
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
`ifdef PC_LINK_STACK_EN
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_clear = 1'b0;
`endif
    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = RUN;
          pc_d    = start_addr;
          fault_d = 1'b0;
          cnt_d   = '0;
`ifdef PC_LINK_STACK_EN
          stk_clear = 1'b1;
`endif
        end
      end
      RUN: begin
        if (halt) begin
          state_d = HALT;
        end else if (stall) begin
          state_d = RUN;
`ifdef PC_LINK_STACK_EN
        end else if (ret_en) begin
          if (stk_empty) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            stk_pop = 1'b1;
            pc_d    = stk_pop_data;
          end
        end else if (call_en) begin
          if (stk_full || lut_null) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            stk_push = 1'b1;
            pc_d     = target;
            cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          end
`endif
        end else if (take) begin
          if (lut_null) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            pc_d  = target;
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          end
        end else if (pc_q == '1) begin
          // Sequential fetch off the top of memory is a fault, not a wrap to 0.
          fault_d = 1'b1;
          state_d = HALT;
        end else begin
          pc_d = pc_q + D'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign prog_ctr = pc_q;
  assign running  = (state_q == RUN);
  assign done     = (state_q == HALT);
  assign fault    = fault_q;
  assign jump_cnt = cnt_q;

endmodule
